// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin front end for a shared signed add/subtract unit.
// Results sit in one output register with valid/ready back-pressure; per-requester sticky overflow.
module addsub_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_v,
  output logic             rsp_c,
  input  logic             rsp_ready,
  input  logic             ovf_clr,
  output logic [1:0]       ovf_sticky
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_v;
  logic             r_c;
  logic [1:0]       r_sticky;

  logic             w_space;
  logic             w_gnt;
  logic             w_fire;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_mode;
  logic [WIDTH+1:0] w_res;
  logic [1:0]       w_sticky_set;

  // Returns {V, C, sum}; operands are zero-extended so the extra bit is carry or borrow.
  function automatic logic [WIDTH+1:0] addsub_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             mode
  );
    logic [WIDTH:0] ext;
    logic           ovf;
    if (mode) begin
      ext = {1'b0, a} - {1'b0, b};
      ovf = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
    end else begin
      ext = {1'b0, a} + {1'b0, b};
      ovf = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
    end
    return {ovf, ext};
  endfunction

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last_grant;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = 1'b0;
    end
  end

  assign w_space    = (r_state == ST_EMPTY) || rsp_ready;
  assign w_fire     = w_space && (req0_valid || req1_valid);
  assign req0_ready = w_space && !w_gnt;
  assign req1_ready = w_space && w_gnt;

  assign w_a    = w_gnt ? req1_a    : req0_a;
  assign w_b    = w_gnt ? req1_b    : req0_b;
  assign w_mode = w_gnt ? req1_mode : req0_mode;
  assign w_res  = addsub_calc(w_a, w_b, w_mode);

  assign w_sticky_set = {w_fire && w_res[WIDTH+1] && w_gnt,
                         w_fire && w_res[WIDTH+1] && !w_gnt};

  // Output register occupancy: a handshake refills, a drain without refill empties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_fire) w_state_nxt = ST_FULL;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_fire)         w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
        else                w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State, pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sum        <= '0;
      r_v          <= 1'b0;
      r_c          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_last_grant <= w_gnt;
        r_id         <= w_gnt;
        r_sum        <= w_res[MSB:0];
        r_c          <= w_res[WIDTH];
        r_v          <= w_res[WIDTH+1];
      end
    end
  end

  // Sticky overflow: a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 2'b00;
    end else begin
      r_sticky <= (ovf_clr ? 2'b00 : r_sticky) | w_sticky_set;
    end
  end

  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_id     = r_id;
  assign rsp_sum    = r_sum;
  assign rsp_v      = r_v;
  assign rsp_c      = r_c;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Randomized and directed bench for addsub_rr_arbiter against an arithmetic-level reference model.
module tb_addsub_rr_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_mode, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_mode, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_id, rsp_v, rsp_c, rsp_ready, ovf_clr;
  logic [W-1:0] rsp_sum;
  logic [1:0]   ovf_sticky;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic         m_full, m_last, m_id, m_v, m_c;
  logic [W-1:0] m_sum;
  logic [1:0]   m_sticky;
  logic         last_fire, last_g;
  int           wait0, wait1;

  addsub_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_v(rsp_v), .rsp_c(rsp_c),
    .rsp_ready(rsp_ready), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Signed arithmetic on integers: overflow means the true result leaves the W-bit range.
  task automatic ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          output logic [W-1:0] s, output logic v, output logic c);
    int sa, sb, ua, ub, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    r  = m ? (sa - sb) : (sa + sb);
    v  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    s  = r[W-1:0];
    c  = m ? (ua < ub) : ((ua + ub) >= (1 << W));
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_sum = '0; m_v = 1'b0; m_c = 1'b0;
    m_sticky = 2'b00; wait0 = 0; wait1 = 0;
  endtask

  // One clock: check readies against the model, advance model at the edge, check outputs.
  task automatic tick();
    logic sp, g, fr, rr, clr, v, c;
    logic [W-1:0] s;
    #1;
    rr  = rsp_ready;
    clr = ovf_clr;
    sp  = !m_full || rr;
    g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
    fr  = sp && (req0_valid || req1_valid);
    if (req0_valid) chk("req0_ready", {31'd0, req0_ready}, {31'd0, sp && !g});
    if (req1_valid) chk("req1_ready", {31'd0, req1_ready}, {31'd0, sp && g});
    if (fr) begin
      if (req0_valid && g)  wait0++;
      if (req1_valid && !g) wait1++;
      if (g) wait1 = 0; else wait0 = 0;
      chk("starve", {31'd0, (wait0 <= 1) && (wait1 <= 1)}, 32'd1);
    end
    if (g) ref_calc(req1_a, req1_b, req1_mode, s, v, c);
    else   ref_calc(req0_a, req0_b, req0_mode, s, v, c);
    @(posedge clk);
    if (fr) begin
      m_full = 1'b1; m_id = g; m_sum = s; m_v = v; m_c = c; m_last = g;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
    if (clr) m_sticky = 2'b00;
    if (fr && v) m_sticky[g] = 1'b1;
    last_fire = fr;
    last_g    = g;
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
    chk("ovf_sticky", {30'd0, ovf_sticky}, {30'd0, m_sticky});
    if (m_full) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_sum", {28'd0, rsp_sum}, {28'd0, m_sum});
      chk("rsp_v", {31'd0, rsp_v}, {31'd0, m_v});
      chk("rsp_c", {31'd0, rsp_c}, {31'd0, m_c});
    end
  endtask

  // Single-requester directed op with constant expected result, one cycle after handshake.
  task automatic op(input string tag, input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic m, input logic [W-1:0] es, input logic ev, input logic ec);
    rsp_ready = 1'b1;
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m; end
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, r});
    chk({tag, "_sum"}, {28'd0, rsp_sum}, {28'd0, es});
    chk({tag, "_v"}, {31'd0, rsp_v}, {31'd0, ev});
    chk({tag, "_c"}, {31'd0, rsp_c}, {31'd0, ec});
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_id"}, {31'd0, rsp_id}, 32'd0);
    chk({tag, "_sum"}, {28'd0, rsp_sum}, 32'd0);
    chk({tag, "_vc"}, {30'd0, rsp_v, rsp_c}, 32'd0);
    chk({tag, "_sticky"}, {30'd0, ovf_sticky}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] snap_sum;
    logic [2:0]   snap_misc;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_mode = 1'b0;
    rsp_ready = 1'b0; ovf_clr = 1'b0;
    last_fire = 1'b0; last_g = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // directed arithmetic
    op("add_7p1", 1'b0, 4'd7, 4'd1, 1'b0, 4'b1000, 1'b1, 1'b0);
    op("add_m8m8", 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    op("sub_3m5", 1'b0, 4'd3, 4'd5, 1'b1, 4'b1110, 1'b0, 1'b1);
    op("sub_m8m1", 1'b0, 4'b1000, 4'd1, 1'b1, 4'b0111, 1'b1, 1'b0);
    op("sub_5m3", 1'b0, 4'd5, 4'd3, 1'b1, 4'b0010, 1'b0, 1'b0);

    // sticky flags
    ovf_clr = 1'b1; rsp_ready = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr0", {30'd0, ovf_sticky}, 32'd0);
    op("stk_r1", 1'b1, 4'd7, 4'd1, 1'b0, 4'b1000, 1'b1, 1'b0);
    chk("sticky_set", {30'd0, ovf_sticky}, 32'd2);
    ovf_clr = 1'b1;
    op("stk_clrset", 1'b1, 4'd7, 4'd1, 1'b0, 4'b1000, 1'b1, 1'b0);
    chk("sticky_setwins", {30'd0, ovf_sticky}, 32'd2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_clr", {30'd0, ovf_sticky}, 32'd0);

    // reset while FULL and stalled
    op("pre_rst", 1'b0, 4'd5, 4'd3, 1'b1, 4'b0010, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // contention: grants alternate starting with req0
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_mode = 1'($urandom);
    req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_mode = 1'($urandom);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cont_id", {31'd0, rsp_id}, k % 2);
      if (last_g) begin req1_a = 4'($urandom); req1_b = 4'($urandom); req1_mode = 1'($urandom); end
      else        begin req0_a = 4'($urandom); req0_b = 4'($urandom); req0_mode = 1'($urandom); end
    end

    // back-pressure: stalled five cycles, then drain and refill together
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    snap_sum   = rsp_sum;
    snap_misc  = {rsp_id, rsp_v, rsp_c};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_r0", {31'd0, req0_ready}, 32'd0);
      chk("bp_r1", {31'd0, req1_ready}, 32'd0);
      chk("bp_sum", {28'd0, rsp_sum}, {28'd0, snap_sum});
      chk("bp_misc", {29'd0, rsp_id, rsp_v, rsp_c}, {29'd0, snap_misc});
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_r0", {31'd0, req0_ready}, 32'd1);
    tick();
    chk("bp_refill_id", {31'd0, rsp_id}, 32'd0);
    req0_valid = 1'b0;

    // random traffic; requesters hold valid and operands until accepted
    for (int k = 0; k < 400; k++) begin
      if (last_fire && !last_g) req0_valid = 1'b0;
      if (last_fire && last_g)  req1_valid = 1'b0;
      if (!req0_valid && ($urandom_range(0, 3) != 0)) begin
        req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_mode = 1'($urandom);
      end
      if (!req1_valid && ($urandom_range(0, 3) != 0)) begin
        req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_mode = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
